// File: rtl/veerwolf_io_pkg.sv
// veerwolf_io_pkg: shared IRQ mode encodings and debounce counter sizing
package veerwolf_io_pkg;
  localparam int IRQ_RISE = 0;
  localparam int IRQ_FALL = 1;
  localparam int IRQ_BOTH = 2;
  function automatic int dbc_w(input int cycles);
    return cycles < 1 ? 1 : $clog2(cycles + 1);
  endfunction
endpackage

// File: rtl/veerwolf_sw_channel.sv
// veerwolf_sw_channel: synchroniser, debouncer, edge detector and pending flag for one switch
module veerwolf_sw_channel
  import veerwolf_io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int IRQ_MODE        = IRQ_BOTH
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_sw,
  input  logic i_clr,
  output logic o_sw,
  output logic o_pend
);
  localparam int W = dbc_w(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES > 0 ? DEBOUNCE_CYCLES - 1 : 0);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic sw_q, sw_d, pend_q, pend_d, sync_lvl, edge_hit;
  always_comb begin
    sync_lvl = sync_q[SYNC_STAGES-1];
    sync_d = {sync_q[SYNC_STAGES-2:0], i_sw};
    cnt_d = '0;
    sw_d = sw_q;
    if (DEBOUNCE_CYCLES == 0) sw_d = sync_lvl;
    else if (sync_lvl != sw_q) begin
      if (cnt_q == LAST) sw_d = sync_lvl;
      else cnt_d = cnt_q + 1'b1;
    end
    edge_hit = IRQ_MODE == IRQ_RISE ? sw_d & ~sw_q :
               IRQ_MODE == IRQ_FALL ? ~sw_d & sw_q : sw_d ^ sw_q;
    // a new edge outranks a coincident clear so no event is lost
    pend_d = edge_hit | (pend_q & ~i_clr);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      cnt_q  <= '0;
      sw_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      sw_q   <= sw_d;
      pend_q <= pend_d;
    end
  end
  assign o_sw   = sw_q;
  assign o_pend = pend_q;
endmodule

// File: rtl/veerwolf_io_ctrl.sv
// veerwolf_io_ctrl: switch debounce/IRQ front-end and PWM-dimmed LED pipeline for VeeRwolf GPIO
module veerwolf_io_ctrl
  import veerwolf_io_pkg::*;
#(
  parameter int N_SW            = 16,
  parameter int N_LED           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int IRQ_MODE        = IRQ_BOTH,
  parameter int LED_PIPE        = 2,
  parameter int PWM_W           = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_SW-1:0]  i_sw,
  output logic [N_SW-1:0]  o_sw,
  input  logic [N_SW-1:0]  i_irq_en,
  input  logic [N_SW-1:0]  i_irq_clr,
  output logic [N_SW-1:0]  o_irq_pend,
  output logic             o_irq,
  input  logic [N_LED-1:0] i_led,
  input  logic [PWM_W-1:0] i_duty,
  output logic [N_LED-1:0] o_led
);
  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    veerwolf_sw_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IRQ_MODE       (IRQ_MODE)
    ) u_ch (
      .clk   (clk),
      .rstn  (rstn),
      .i_sw  (i_sw[i]),
      .i_clr (i_irq_clr[i]),
      .o_sw  (o_sw[i]),
      .o_pend(o_irq_pend[i])
    );
  end
  logic irq_q, irq_d, pwm_on;
  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic [LED_PIPE:0][N_LED-1:0] chain;
  logic [LED_PIPE-1:0][N_LED-1:0] led_q, led_d;
  always_comb begin
    irq_d = |(o_irq_pend & i_irq_en);
    cnt_d = cnt_q + 1'b1;
    pwm_on = (&i_duty) | (cnt_q < i_duty);
    chain = {led_q, i_led};
    led_d = chain[LED_PIPE-1:0];
    // last stage doubles as the PWM gate so dimming adds no latency
    led_d[LED_PIPE-1] = chain[LED_PIPE-1] & {N_LED{pwm_on}};
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_q <= 1'b0;
      cnt_q <= '0;
      led_q <= '0;
    end else begin
      irq_q <= irq_d;
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end
  assign o_irq = irq_q;
  assign o_led = led_q[LED_PIPE-1];
endmodule

// File: tb/tb_veerwolf_io_ctrl.sv
// tb_veerwolf_io_ctrl: directed checks of debounce, IRQ, PWM and async reset behaviour
module tb_veerwolf_io_ctrl;
  logic clk = 1'b0;
  logic rstn;
  logic [15:0] sw, osw, en, clr, pend, led, oled;
  logic irq;
  logic [7:0] duty;
  logic [3:0] r_sw, r_osw, r_en, r_clr, r_pend;
  logic r_irq;
  logic [0:0] r_led, r_oled;
  logic [7:0] r_duty;
  int n_chk = 0, n_pass = 0;
  int changes, sets, at, on_cnt, odd_cnt;
  logic prev_sw, prev_p;

  always #5 clk = ~clk;

  veerwolf_io_ctrl #(
    .N_SW(16), .N_LED(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .IRQ_MODE(2), .LED_PIPE(2), .PWM_W(8)
  ) u_dut (
    .clk(clk), .rstn(rstn), .i_sw(sw), .o_sw(osw), .i_irq_en(en),
    .i_irq_clr(clr), .o_irq_pend(pend), .o_irq(irq), .i_led(led),
    .i_duty(duty), .o_led(oled)
  );

  veerwolf_io_ctrl #(
    .N_SW(4), .N_LED(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .IRQ_MODE(0), .LED_PIPE(1), .PWM_W(8)
  ) u_rise (
    .clk(clk), .rstn(rstn), .i_sw(r_sw), .o_sw(r_osw), .i_irq_en(r_en),
    .i_irq_clr(r_clr), .o_irq_pend(r_pend), .o_irq(r_irq), .i_led(r_led),
    .i_duty(r_duty), .o_led(r_oled)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mtick;
    tick();
    if (osw[3] != prev_sw) changes++;
    if (pend[3] && !prev_p) sets++;
    prev_sw = osw[3];
    prev_p = pend[3];
  endtask

  task automatic count_led;
    on_cnt = 0;
    odd_cnt = 0;
    repeat (256) begin
      tick();
      if (oled == 16'hffff) on_cnt++;
      else if (oled != 16'h0) odd_cnt++;
    end
  endtask

  initial begin
    rstn = 1'b0;
    sw = '0; en = '0; clr = '0; led = '0; duty = '0;
    r_sw = '0; r_en = '0; r_clr = '0; r_led = '0; r_duty = '0;
    repeat (3) tick();
    chk("rst_osw", osw, 0);
    chk("rst_pend", pend, 0);
    chk("rst_irq", irq, 0);
    chk("rst_led", oled, 0);
    rstn = 1'b1;
    repeat (3) tick();

    sw[0] = 1'b1;
    repeat (5) tick();
    chk("step_early", osw[0], 0);
    tick();
    chk("step_osw", osw[0], 1);
    chk("step_pend", pend[0], 1);

    clr = 16'hffff;
    tick();
    clr = '0;
    chk("clr_all", pend, 0);
    en = 16'h0001;
    sw = 16'h0020;
    repeat (5) tick();
    chk("irq_pend_early", pend, 0);
    tick();
    chk("irq_pend", pend, 16'h0021);
    chk("irq_reg_lag", irq, 0);
    tick();
    chk("irq_on", irq, 1);
    clr = 16'h0001;
    tick();
    clr = '0;
    chk("irq_clr_pend", pend, 16'h0020);
    chk("irq_still", irq, 1);
    tick();
    chk("irq_off", irq, 0);
    sw = '0;
    repeat (5) tick();
    clr = 16'h0020;
    tick();
    clr = '0;
    chk("set_wins", pend, 16'h0020);
    clr = 16'h0020;
    tick();
    clr = '0;
    chk("clr_ch5", pend, 0);

    prev_sw = osw[3];
    prev_p = pend[3];
    changes = 0; sets = 0; at = 0;
    sw[3] = 1'b1;
    repeat (2) mtick();
    sw[3] = 1'b0;
    repeat (2) mtick();
    sw[3] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      mtick();
      if (changes == 1 && at == 0) at = k;
    end
    chk("bnc_changes", changes, 1);
    chk("bnc_lat", at, 6);
    chk("bnc_sets", sets, 1);
    chk("bnc_osw", osw[3], 1);

    r_sw[2] = 1'b1;
    repeat (6) tick();
    chk("rise_osw", r_osw, 4'h4);
    chk("rise_pend", r_pend, 4'h4);
    r_clr = 4'h4;
    tick();
    r_clr = '0;
    r_sw[2] = 1'b0;
    repeat (5) tick();
    chk("fall_early", r_osw, 4'h4);
    tick();
    chk("fall_osw", r_osw, 4'h0);
    chk("fall_nopend", r_pend, 4'h0);
    tick();
    chk("fall_nopend2", r_pend, 4'h0);

    led = 16'hffff;
    duty = 8'd64;
    repeat (5) tick();
    count_led();
    chk("pwm64_on", on_cnt, 64);
    chk("pwm64_odd", odd_cnt, 0);
    duty = 8'd0;
    repeat (3) tick();
    count_led();
    chk("pwm0_on", on_cnt, 0);
    led = '0;
    duty = 8'd255;
    repeat (2) tick();
    led = 16'hffff;
    tick();
    chk("pipe_lat1", oled, 0);
    tick();
    chk("pipe_lat2", oled, 16'hffff);
    count_led();
    chk("pwm255_on", on_cnt, 256);

    en = 16'hffff;
    sw = 16'h0009;
    repeat (3) tick();
    chk("pre_rst_irq", irq, 1);
    chk("pre_rst_led", oled, 16'hffff);
    #1 rstn = 1'b0;
    #1;
    chk("arst_osw", osw, 0);
    chk("arst_pend", pend, 0);
    chk("arst_irq", irq, 0);
    chk("arst_led", oled, 0);
    #2 rstn = 1'b1;
    repeat (5) tick();
    chk("reacq_early", osw, 0);
    tick();
    chk("reacq_osw", osw, 16'h0009);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
